// File: rtl/mtm_alu_frame_rx.sv
// Serial ALU operand receiver: 11-bit frames -> {A, B, opcode} operand set plus one-hot error pulses.
// Latency: outputs and err pulse appear the cycle after the stop bit of the relevant frame is sampled.
// Backpressure: out_valid holds until out_ready; a packet completing while held and unready is dropped as overrun.
module mtm_alu_frame_rx #(
  parameter int         DATA_W  = 32,
  parameter logic [7:0] OP_MASK = 8'b0011_0011
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [2:0]        op_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err_valid,
  output logic [3:0]        err_code
);

  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = $clog2(2 * NB + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(2 * NB);

  typedef enum logic [1:0] {IDLE, TYPE, DATA, STOP} state_t;

  state_t              state_q;
  logic                type_q;
  logic [2:0]          bit_cnt_q;
  logic [7:0]          shift_q;
  logic [CNT_W-1:0]    byte_cnt_q;
  logic [2*DATA_W-1:0] asm_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [2:0]          op_q;
  logic                out_valid_q;
  logic                err_valid_q;
  logic [3:0]          err_code_q;

  // Decode of the frame whose stop bit is being sampled this cycle
  logic       good_stop, frame_err, data_err, op_err, ovr_err, data_acc, load;
  logic       cnt_full, op_legal, held;
  logic [2:0] cmd_op;

  // Classify the completed frame; conditions are mutually exclusive, which encodes frame > data > op > overrun
  always_comb begin
    cmd_op    = shift_q[6:4];
    cnt_full  = (byte_cnt_q == FULL_CNT);
    op_legal  = OP_MASK[cmd_op];
    held      = out_valid_q && !out_ready;
    good_stop = (state_q == STOP) && sin;
    frame_err = (state_q == STOP) && !sin;
    data_err  = good_stop && (type_q != cnt_full);
    data_acc  = good_stop && !type_q && !cnt_full;
    op_err    = good_stop && type_q && cnt_full && !op_legal;
    ovr_err   = good_stop && type_q && cnt_full && op_legal && held;
    load      = good_stop && type_q && cnt_full && op_legal && !held;
  end

  // Frame FSM, packet assembly and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      type_q      <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      byte_cnt_q  <= '0;
      asm_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      out_valid_q <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      err_valid_q <= frame_err | data_err | op_err | ovr_err;
      err_code_q  <= {ovr_err, op_err, data_err, frame_err};

      case (state_q)
        IDLE: if (!sin) state_q <= TYPE;
        TYPE: begin
          type_q    <= sin;
          bit_cnt_q <= '0;
          state_q   <= DATA;
        end
        DATA: begin
          shift_q   <= {shift_q[6:0], sin};
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_q <= STOP;
        end
        default: state_q <= IDLE;
      endcase

      // Any terminating event (error or load) restarts packet assembly
      if (frame_err || data_err || op_err || ovr_err || load) begin
        byte_cnt_q <= '0;
      end else if (data_acc) begin
        byte_cnt_q <= byte_cnt_q + CNT_W'(1);
        asm_q      <= {asm_q[2*DATA_W-9:0], shift_q};
      end

      if (load) begin
        a_q         <= asm_q[2*DATA_W-1:DATA_W];
        b_q         <= asm_q[DATA_W-1:0];
        op_q        <= cmd_op;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign op_out    = op_q;
  assign out_valid = out_valid_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_mtm_alu_frame_rx.sv
// Directed bench for mtm_alu_frame_rx at DATA_W=32 and DATA_W=8.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
// Both instances share the serial line; each test checks only the instance it targets.
module tb_mtm_alu_frame_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sin = 1'b1;
  logic        out_ready = 1'b0;
  logic [31:0] a32, b32;
  logic [2:0]  op32;
  logic        v32, ev32;
  logic [3:0]  ec32;
  logic [7:0]  a8, b8;
  logic [2:0]  op8;
  logic        v8, ev8;
  logic [3:0]  ec8;

  int checks = 0;
  int errors = 0;
  int pulses32 = 0;
  int code_bad = 0;

  mtm_alu_frame_rx #(.DATA_W(32), .OP_MASK(8'b0011_0011)) dut32 (
    .clk(clk), .rst(rst), .sin(sin), .a_out(a32), .b_out(b32), .op_out(op32),
    .out_valid(v32), .out_ready(out_ready), .err_valid(ev32), .err_code(ec32));

  mtm_alu_frame_rx #(.DATA_W(8), .OP_MASK(8'b0011_0011)) dut8 (
    .clk(clk), .rst(rst), .sin(sin), .a_out(a8), .b_out(b8), .op_out(op8),
    .out_valid(v8), .out_ready(out_ready), .err_valid(ev8), .err_code(ec8));

  always #5 clk = ~clk;

  // Error pulse bookkeeping and idle err_code watch
  always @(negedge clk) begin
    if (ev32) pulses32++;
    if ((!ev32 && ec32 !== 4'b0) || (!ev8 && ec8 !== 4'b0)) code_bad++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic b);
    @(posedge clk);
    #1 sin = b;
  endtask

  task automatic send_frame(input logic t, input logic [7:0] p, input logic stop, input logic rdy_stop);
    drive(1'b0);
    drive(t);
    for (int i = 7; i >= 0; i--) drive(p[i]);
    @(posedge clk);
    #1 sin = stop;
    if (rdy_stop) out_ready = 1'b1;
  endtask

  task automatic send_data32(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_frame(1'b0, w[i*8 +: 8], 1'b1, 1'b0);
  endtask

  task automatic send_packet32(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, input logic rdy_stop);
    send_data32(a);
    send_data32(b);
    send_frame(1'b1, {1'b0, op, 4'b0}, 1'b1, rdy_stop);
  endtask

  // Stop bit gets sampled at the next posedge; observe its effect on the following negedge
  task automatic settle();
    drive(1'b1);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (a32 !== 32'h0) begin errors++; $display("FAIL reset_a got %h exp 0", a32); end
    checks++; if (b32 !== 32'h0) begin errors++; $display("FAIL reset_b got %h exp 0", b32); end
    checks++; if (op32 !== 3'd0) begin errors++; $display("FAIL reset_op got %0d exp 0", op32); end
    checks++; if (v32 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", v32); end
    checks++; if ({ev32, ec32} !== 5'b0) begin errors++; $display("FAIL reset_err got %b/%b exp 0/0000", ev32, ec32); end
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send_packet32(32'h12345678, 32'h000000FF, 3'd4, 1'b0);
    settle();
    checks++; if (v32 !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", v32); end
    checks++; if (a32 !== 32'h12345678) begin errors++; $display("FAIL basic_a got %h exp 12345678", a32); end
    checks++; if (b32 !== 32'h000000FF) begin errors++; $display("FAIL basic_b got %h exp 000000ff", b32); end
    checks++; if (op32 !== 3'd4) begin errors++; $display("FAIL basic_op got %0d exp 4", op32); end
    checks++; if (ev32 !== 1'b0) begin errors++; $display("FAIL basic_err got %b exp 0", ev32); end
    @(negedge clk);
    checks++; if (v32 !== 1'b0) begin errors++; $display("FAIL basic_handshake_valid got %b exp 0", v32); end
    checks++; if (a32 !== 32'h12345678) begin errors++; $display("FAIL basic_hold_a got %h exp 12345678", a32); end
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    send_packet32(32'h12345678, 32'h000000FF, 3'd4, 1'b0);
    settle();
    checks++; if (v32 !== 1'b1) begin errors++; $display("FAIL ovr_first_valid got %b exp 1", v32); end
    send_packet32(32'h1, 32'h2, 3'd0, 1'b0);
    settle();
    checks++; if ({ev32, ec32} !== 5'b1_1000) begin errors++; $display("FAIL ovr_err got %b/%b exp 1/1000", ev32, ec32); end
    checks++; if ({v32, a32, b32, op32} !== {1'b1, 32'h12345678, 32'h000000FF, 3'd4}) begin
      errors++; $display("FAIL ovr_hold got v=%b a=%h b=%h op=%0d exp 1/12345678/000000ff/4", v32, a32, b32, op32); end
    @(negedge clk);
    checks++; if ({ev32, ec32} !== 5'b0) begin errors++; $display("FAIL ovr_pulse_width got %b/%b exp 0/0000", ev32, ec32); end
    // Ready rises exactly in the completion cycle: new packet replaces the held one without error
    send_packet32(32'hAABBCCDD, 32'h11223344, 3'd5, 1'b1);
    settle();
    checks++; if ({v32, ev32} !== 2'b10) begin errors++; $display("FAIL ovr_ready_load got v=%b err=%b exp 1/0", v32, ev32); end
    checks++; if ({a32, b32, op32} !== {32'hAABBCCDD, 32'h11223344, 3'd5}) begin
      errors++; $display("FAIL ovr_ready_data got %h/%h/%0d exp aabbccdd/11223344/5", a32, b32, op32); end
    @(negedge clk);
    checks++; if (v32 !== 1'b0) begin errors++; $display("FAIL ovr_drain got %b exp 0", v32); end
  endtask

  task automatic test_short_packet();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_frame(1'b0, 8'h10 + 8'(i), 1'b1, 1'b0);
    send_frame(1'b1, {1'b0, 3'd4, 4'b0}, 1'b1, 1'b0);
    settle();
    checks++; if ({ev32, ec32} !== 5'b1_0010) begin errors++; $display("FAIL short_err got %b/%b exp 1/0010", ev32, ec32); end
    checks++; if (v32 !== 1'b0) begin errors++; $display("FAIL short_valid got %b exp 0", v32); end
    send_packet32(32'hCAFEF00D, 32'h00000001, 3'd1, 1'b0);
    settle();
    checks++; if ({v32, ev32, a32, op32} !== {2'b10, 32'hCAFEF00D, 3'd1}) begin
      errors++; $display("FAIL short_recover got v=%b e=%b a=%h op=%0d exp 1/0/cafef00d/1", v32, ev32, a32, op32); end
  endtask

  task automatic test_overflow();
    out_ready = 1'b1;
    send_data32(32'h01020304);
    send_data32(32'h05060708);
    send_frame(1'b0, 8'h99, 1'b1, 1'b0);
    settle();
    checks++; if ({ev32, ec32} !== 5'b1_0010) begin errors++; $display("FAIL overflow_err got %b/%b exp 1/0010", ev32, ec32); end
    send_packet32(32'h5, 32'h6, 3'd0, 1'b0);
    settle();
    checks++; if ({v32, ev32, a32, b32} !== {2'b10, 32'h5, 32'h6}) begin
      errors++; $display("FAIL overflow_recover got v=%b e=%b a=%h b=%h exp 1/0/5/6", v32, ev32, a32, b32); end
  endtask

  task automatic test_frame_err();
    out_ready = 1'b1;
    send_frame(1'b0, 8'hAA, 1'b1, 1'b0);
    send_frame(1'b0, 8'hBB, 1'b1, 1'b0);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0);
    settle();
    checks++; if ({ev32, ec32} !== 5'b1_0001) begin errors++; $display("FAIL frame_err got %b/%b exp 1/0001", ev32, ec32); end
    send_packet32(32'hDEADBEEF, 32'h0BADF00D, 3'd5, 1'b0);
    settle();
    checks++; if ({v32, ev32, a32, b32, op32} !== {2'b10, 32'hDEADBEEF, 32'h0BADF00D, 3'd5}) begin
      errors++; $display("FAIL frame_recover got v=%b e=%b a=%h b=%h op=%0d exp 1/0/deadbeef/0badf00d/5", v32, ev32, a32, b32, op32); end
  endtask

  task automatic test_op_err();
    out_ready = 1'b1;
    @(negedge clk);
    send_packet32(32'h1111, 32'h2222, 3'd2, 1'b0);
    settle();
    checks++; if ({ev32, ec32} !== 5'b1_0100) begin errors++; $display("FAIL op_err got %b/%b exp 1/0100", ev32, ec32); end
    checks++; if ({v32, a32, op32} !== {1'b0, 32'hDEADBEEF, 3'd5}) begin
      errors++; $display("FAIL op_untouched got v=%b a=%h op=%0d exp 0/deadbeef/5", v32, a32, op32); end
    @(negedge clk);
    checks++; if (pulses32 !== 5) begin errors++; $display("FAIL err_pulse_total got %0d exp 5", pulses32); end
  endtask

  task automatic test_reset_mid_packet();
    send_data32(32'h0A0B0C0D);
    send_frame(1'b0, 8'hEE, 1'b1, 1'b0);
    drive(1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if ({a32, b32, op32, v32, ev32, ec32} !== '0) begin
      errors++; $display("FAIL midrst_outputs got a=%h b=%h op=%0d v=%b e=%b c=%b exp all 0", a32, b32, op32, v32, ev32, ec32); end
    send_packet32(32'h87654321, 32'h10, 3'd1, 1'b0);
    settle();
    checks++; if ({v32, ev32, a32, b32} !== {2'b10, 32'h87654321, 32'h10}) begin
      errors++; $display("FAIL midrst_recover got v=%b e=%b a=%h b=%h exp 1/0/87654321/10", v32, ev32, a32, b32); end
    @(negedge clk);
    checks++; if (pulses32 !== 5) begin errors++; $display("FAIL midrst_no_err got %0d pulses exp 5", pulses32); end
  endtask

  task automatic test_width8();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    send_frame(1'b0, 8'hA5, 1'b1, 1'b0);
    send_frame(1'b0, 8'h5A, 1'b1, 1'b0);
    send_frame(1'b1, {1'b0, 3'd1, 4'b0}, 1'b1, 1'b0);
    settle();
    checks++; if ({v8, ev8} !== 2'b10) begin errors++; $display("FAIL w8_valid got v=%b e=%b exp 1/0", v8, ev8); end
    checks++; if ({a8, b8, op8} !== {8'hA5, 8'h5A, 3'd1}) begin
      errors++; $display("FAIL w8_data got %h/%h/%0d exp a5/5a/1", a8, b8, op8); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_short_packet();
    test_overflow();
    test_frame_err();
    test_op_err();
    test_reset_mid_packet();
    test_width8();
    @(negedge clk);
    checks++; if (code_bad !== 0) begin errors++; $display("FAIL idle_err_code got %0d nonzero cycles exp 0", code_bad); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
